// File: rtl/nf_dm_responder.sv
// nf_dm_responder: data-memory bus slave with private word RAM and wait states.
// Optional out-of-range error reporting when NF_DM_RESP_ERR_EN is defined.
module nf_dm_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr_dm,
   input  logic        we_dm,
   input  logic [31:0] wd_dm,
   input  logic        req_dm,
   output logic [31:0] rd_dm,
   output logic        req_ack_dm
`ifdef NF_DM_RESP_ERR_EN
   ,
   output logic        err_dm
`endif
);
   localparam int         AW = $clog2(DEPTH);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t        state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   logic [AW-1:0] idx_q, idx_in, acc_idx;
   logic [31:0]   wd_q, acc_wd;
   logic          we_q, acc_we;
   logic          oor_q, oor_in, acc_oor;
   logic          lat, acc;
   logic [31:0]   mem [DEPTH];
   logic          unused;

   assign idx_in = addr_dm[AW+1:2];
   assign unused = ^{addr_dm[31:AW+2], addr_dm[1:0]};

`ifdef NF_DM_RESP_ERR_EN
   assign oor_in = |addr_dm[31:AW+2];
   assign err_dm = (state == ACK) && oor_q;
`else
   assign oor_in = 1'b0;
`endif

   assign req_ack_dm = (state == ACK);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state, counter update and access strobe.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      lat      = 1'b0;
      acc      = 1'b0;
      acc_we   = we_q;
      acc_idx  = idx_q;
      acc_wd   = wd_q;
      acc_oor  = oor_q;
      unique case (state)
         IDLE: begin
            if (req_dm) begin
               lat    = 1'b1;
               cnt_nx = WC;
               if (WAIT_CYCLES > 0) begin
                  state_nx = WAIT;
               end else begin
                  acc      = 1'b1;
                  acc_we   = we_dm;
                  acc_idx  = idx_in;
                  acc_wd   = wd_dm;
                  acc_oor  = oor_in;
                  state_nx = ACK;
               end
            end
         end
         WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               acc      = 1'b1;
               state_nx = ACK;
            end
         end
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, wait counter and registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= 4'd0;
         idx_q <= '0;
         we_q  <= 1'b0;
         wd_q  <= 32'd0;
         oor_q <= 1'b0;
         rd_dm <= 32'd0;
      end else begin
         cnt <= cnt_nx;
         if (lat) begin
            idx_q <= idx_in;
            we_q  <= we_dm;
            wd_q  <= wd_dm;
            oor_q <= oor_in;
         end
         if (acc && !acc_we)
            rd_dm <= acc_oor ? 32'd0 : mem[acc_idx];
      end
   end

   // RAM write port; reset drops a write landing on the same edge.
   always_ff @(posedge clk) begin
      if (!reset && acc && acc_we && !acc_oor)
         mem[acc_idx] <= acc_wd;
   end

endmodule

// File: tb/tb_nf_dm_responder.sv
// tb_nf_dm_responder: three responders (0, 1 and 3 wait states) checked
// against directed vectors and a word-array reference model.
module tb_nf_dm_responder;
   logic        clk = 1'b0;
   logic        reset_a [3];
   logic        req_a   [3];
   logic        we_a    [3];
   logic [31:0] addr_a  [3];
   logic [31:0] wd_a    [3];
   logic [31:0] rd_a    [3];
   logic        ack_a   [3];
   logic        err_a   [3];

   int tests = 0;
   int fails = 0;

   logic [31:0] mem_m [3][256];
   logic [31:0] rd_m  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      nf_dm_responder #(
         .DEPTH(256),
         .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
      ) u_dut (
         .clk(clk),
         .reset(reset_a[g]),
         .addr_dm(addr_a[g]),
         .we_dm(we_a[g]),
         .wd_dm(wd_a[g]),
         .req_dm(req_a[g]),
         .rd_dm(rd_a[g]),
         .req_ack_dm(ack_a[g])
`ifdef NF_DM_RESP_ERR_EN
         ,
         .err_dm(err_a[g])
`endif
      );
`ifndef NF_DM_RESP_ERR_EN
      assign err_a[g] = 1'b0;
`endif
   end

   function automatic int wc(input int k);
      return k == 0 ? 0 : (k == 1 ? 1 : 3);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: word RAM indexed by byte address / 4 modulo depth.
   task automatic model(input int k, input bit we, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] erd,
                        output bit eerr);
      int idx;
      bit oor;
      idx = int'((a / 32'd4) % 32'd256);
      oor = 1'b0;
`ifdef NF_DM_RESP_ERR_EN
      oor = (a >= 32'd1024);
`endif
      if (we) begin
         if (!oor) mem_m[k][idx] = d;
      end else begin
         rd_m[k] = oor ? 32'd0 : mem_m[k][idx];
      end
      erd  = rd_m[k];
      eerr = oor;
   endtask

   // One request on instance k; returns data, err, ack latency, ack width.
   task automatic txn(input int k, input bit we, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output bit er, output int lat, output bit one);
      rd  = 32'd0;
      er  = 1'b0;
      lat = -1;
      @(posedge clk);
      #1;
      req_a[k]  = 1'b1;
      we_a[k]   = we;
      addr_a[k] = a;
      wd_a[k]   = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack_a[k]) begin
            lat = i;
            rd  = rd_a[k];
            er  = err_a[k];
            break;
         end
      end
      @(posedge clk);
      #1;
      req_a[k] = 1'b0;
      @(negedge clk);
      one = !ack_a[k];
   endtask

   task automatic run(input int k, input string nm, input bit we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err);
      logic [31:0] rd;
      bit er, one;
      int lat;
      txn(k, we, a, d, rd, er, lat, one);
      chk($sformatf("k%0d_%s_rd", k, nm), rd, exp_rd);
      chk($sformatf("k%0d_%s_lat", k, nm), 32'(lat), 32'(1 + wc(k)));
      chk($sformatf("k%0d_%s_width", k, nm), 32'(one), 32'd1);
`ifdef NF_DM_RESP_ERR_EN
      chk($sformatf("k%0d_%s_err", k, nm), 32'(er), 32'(exp_err));
`else
      if (exp_err) chk($sformatf("k%0d_%s_err", k, nm), 32'(er), 32'd1);
`endif
   endtask

   task automatic run_m(input int k, input string nm, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
      logic [31:0] erd;
      bit eerr;
      model(k, we, a, d, erd, eerr);
      run(k, nm, we, a, d, erd, eerr);
   endtask

   task automatic b2b(input int k);
      logic [31:0] adr [3];
      logic [31:0] exp [3];
      int prev, n;
      adr[0] = 32'h0; adr[1] = 32'h4; adr[2] = 32'h8;
      exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h33333333;
      prev = -1;
      n    = 0;
      @(posedge clk);
      #1;
      req_a[k]  = 1'b1;
      we_a[k]   = 1'b0;
      addr_a[k] = adr[0];
      for (int i = 0; i < 60 && n < 3; i++) begin
         @(negedge clk);
         if (ack_a[k]) begin
            chk($sformatf("k%0d_b2b%0d_rd", k, n), rd_a[k], exp[n]);
            if (n > 0)
               chk($sformatf("k%0d_b2b%0d_gap", k, n), 32'(i - prev),
                   32'(2 + wc(k)));
            prev = i;
            n++;
            if (n < 3) addr_a[k] = adr[n];
            else req_a[k] = 1'b0;
         end
      end
      req_a[k] = 1'b0;
      chk($sformatf("k%0d_b2b_count", k), 32'(n), 32'd3);
      @(negedge clk);
      chk($sformatf("k%0d_b2b_tail", k), 32'(ack_a[k]), 32'd0);
      rd_m[k] = exp[2];
   endtask

   task automatic mid_reset(input int k);
      int nack;
      run_m(k, "pre20", 1'b1, 32'h20, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      req_a[k]  = 1'b1;
      we_a[k]   = 1'b1;
      addr_a[k] = 32'h20;
      wd_a[k]   = 32'h12345678;
      @(posedge clk);
      #1;
      reset_a[k] = 1'b1;
      req_a[k]   = 1'b0;
      @(posedge clk);
      #1;
      reset_a[k] = 1'b0;
      nack = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_a[k]) nack++;
      end
      chk($sformatf("k%0d_rst_noack", k), 32'(nack), 32'd0);
      chk($sformatf("k%0d_rst_rd", k), rd_a[k], 32'd0);
      rd_m[k] = 32'd0;
      run_m(k, "post20", 1'b0, 32'h20, 32'd0);
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   initial begin
      vec_t tbl[$];
      logic [31:0] erd, a;
      bit eerr;

      for (int k = 0; k < 3; k++) begin
         reset_a[k] = 1'b1;
         req_a[k]   = 1'b0;
         we_a[k]    = 1'b0;
         addr_a[k]  = 32'd0;
         wd_a[k]    = 32'd0;
         rd_m[k]    = 32'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("k%0d_reset_ack", k), 32'(ack_a[k]), 32'd0);
         chk($sformatf("k%0d_reset_rd", k), rd_a[k], 32'd0);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) reset_a[k] = 1'b0;

      tbl.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
      tbl.push_back('{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h0, 32'h11111111, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h4, 32'h22222222, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h8, 32'h33333333, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b0, 32'h8, 32'h0, 32'h33333333, 1'b0});
`ifdef NF_DM_RESP_ERR_EN
      tbl.push_back('{1'b0, 32'h402, 32'h0, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1});
      tbl.push_back('{1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0});
      tbl.push_back('{1'b1, 32'h13, 32'hA5A5A5A5, 32'h11111111, 1'b0});
      tbl.push_back('{1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 1'b0});
`else
      tbl.push_back('{1'b0, 32'h402, 32'h0, 32'h11111111, 1'b0});
      tbl.push_back('{1'b1, 32'h40C, 32'h44444444, 32'h11111111, 1'b0});
      tbl.push_back('{0, 32'hC, 32'h0, 32'h44444444, 1'b0});
      tbl.push_back('{1'b0, 32'hFFFFFC08, 32'h0, 32'h33333333, 1'b0});
      tbl.push_back('{1'b1, 32'h13, 32'hA5A5A5A5, 32'h33333333, 1'b0});
      tbl.push_back('{1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 1'b0});
`endif

      for (int k = 0; k < 3; k++) begin
         foreach (tbl[i]) begin
            model(k, tbl[i].we, tbl[i].addr, tbl[i].wd, erd, eerr);
            run(k, $sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr,
                tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err);
         end
         b2b(k);
      end

      mid_reset(1);
      mid_reset(2);

      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 8; w++)
            run_m(k, $sformatf("pre%0d", w), 1'b1, 32'(w * 4), $urandom());
         for (int t = 0; t < 25; t++) begin
            a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
`ifdef NF_DM_RESP_ERR_EN
            if ($urandom_range(0, 3) == 0)
               a = a | (($urandom() | 32'h400) & 32'hFFFFFC00);
`else
            a = a | ($urandom() & 32'hFFFFFC00);
`endif
            run_m(k, $sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                  a, $urandom());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
